// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared types, segment codes and BCD decode for score_display
package score_display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} disp_state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// rtl/score_display_bin2bcd_seq.sv - sequential 7-bit double-dabble, one iteration per step
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        load,
    input  logic [6:0]  bin,
    input  logic        step,
    output logic [11:0] bcd
);

    // {hundreds, tens, ones, remaining binary bits}
    logic [18:0] sr;
    logic [18:0] adjusted;

    always_comb begin
        adjusted = sr;
        if (sr[18:15] >= 4'd5) adjusted[18:15] = sr[18:15] + 4'd3;
        if (sr[14:11] >= 4'd5) adjusted[14:11] = sr[14:11] + 4'd3;
        if (sr[10:7]  >= 4'd5) adjusted[10:7]  = sr[10:7]  + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            sr <= '0;
        end else if (load) begin
            sr <= {12'd0, bin};
        end else if (step) begin
            sr <= {adjusted[17:0], 1'b0};
        end
    end

    assign bcd = sr[18:7];

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - converts current/high score to blanked, blinking 7-segment banks
module score_display
    import score_display_pkg::*;
#(
    parameter int BLINK_HALF = 10_000_000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [6:0]  currScore,
    input  logic [6:0]  highScore,
    input  logic        isGameComplete,
    output logic [20:0] currSeg,
    output logic [20:0] highSeg,
    output logic        busy
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [20:0] RESET_SEGS = BLANK_LZ ? {SEG_BLANK, SEG_BLANK, SEG_0}
                                                  : {SEG_0, SEG_0, SEG_0};

    disp_state_t      state;
    logic [2:0]       iter;
    logic [13:0]      snapshot;
    logic [20:0]      curr_reg;
    logic [20:0]      high_reg;
    logic [CNT_W-1:0] blink_cnt;
    logic [11:0]      curr_bcd;
    logic [11:0]      high_bcd;
    logic             load;
    logic             step;
    logic             blink_off;

    assign load = (state == IDLE) && ({currScore, highScore} != snapshot);
    assign step = (state == CONV);

    bin2bcd_seq u_curr (
        .clk  (clk),
        .nRst (nRst),
        .load (load),
        .bin  (currScore),
        .step (step),
        .bcd  (curr_bcd)
    );

    bin2bcd_seq u_high (
        .clk  (clk),
        .nRst (nRst),
        .load (load),
        .bin  (highScore),
        .step (step),
        .bcd  (high_bcd)
    );

    function automatic logic [20:0] to_digits(input logic [11:0] bcd);
        logic hz;
        logic tz;
        seg_t h;
        seg_t t;
        hz = (bcd[11:8] == 4'd0);
        tz = (bcd[7:4] == 4'd0);
        h  = (BLANK_LZ && hz) ? SEG_BLANK : bcd_to_seg(bcd[11:8]);
        t  = (BLANK_LZ && hz && tz) ? SEG_BLANK : bcd_to_seg(bcd[7:4]);
        return {h, t, bcd_to_seg(bcd[3:0])};
    endfunction

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            iter     <= 3'd0;
            busy     <= 1'b0;
            snapshot <= '0;
            curr_reg <= RESET_SEGS;
            high_reg <= RESET_SEGS;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        snapshot <= {currScore, highScore};
                        iter     <= 3'd0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (iter == 3'd6) begin
                        state <= UPDATE;
                    end else begin
                        iter <= iter + 3'd1;
                    end
                end
                UPDATE: begin
                    curr_reg <= to_digits(curr_bcd);
                    high_reg <= to_digits(high_bcd);
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst || !isGameComplete) begin
            blink_cnt <= '0;
        end else if (blink_cnt == CNT_W'(2 * BLINK_HALF - 1)) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Qualifying with the live flag lets deassertion restore the bank without waiting an edge.
    assign blink_off = isGameComplete && (blink_cnt >= CNT_W'(BLINK_HALF));

    assign currSeg = curr_reg;
    assign highSeg = blink_off ? '0 : high_reg;

endmodule
